// File: rtl/cpu_run_controller_pkg.sv
// Shared types and constants for the CPU run controller and its button front end.
package cpu_run_controller_pkg;

  typedef enum logic [2:0] {
    CS_RESET_HOLD,
    CS_IDLE,
    CS_RUN,
    CS_STEP,
    CS_HALTED
  } ControllerState;

  localparam int CPU_PHASES = 4;

  // Saturating increment so the cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_run_controller_button_edge.sv
// Board button front end: 2-flop synchroniser, stable-count debounce and a
// one-cycle pulse on each accepted rising edge.
module button_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync0;
  logic          sync1;
  logic          stable;
  logic [CW-1:0] cnt;

  // The synchronised level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive samples before it is taken; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      press <= 1'b0;
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync1;
        cnt    <= '0;
        press  <= sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/pause/step/restart sequencer for the single-cycle CPU: derives the CPU
// clock-enable pulse from clkX4, holds the CPU in reset and counts executed cycles.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int PHASES          = CPU_PHASES,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_HOLD_CYCLES = 8,
  parameter int MAX_CYCLES      = 0
) (
  input  logic                      clkX4,
  input  logic                      rst,
  input  logic                      btnC,
  input  logic                      btnU,
  input  logic                      btnD,
  input  logic                      cpuHaltReq,
  output logic                      cpuRst,
  output logic                      cpuClkEn,
  output logic [$clog2(PHASES)-1:0] cpuPhase,
  output ControllerState            runState,
  output logic [31:0]               cycleCount
);

  localparam int PW = $clog2(PHASES);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);

  ControllerState state_q, state_d;
  logic [PW-1:0]  phase_q;
  logic [HW-1:0]  hold_q;
  logic           pause_q;
  logic [31:0]    count_q;
  logic           press_c, press_u, press_d;
  logic           in_cycle, pulse, halt_now;

  button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (
    .clk(clkX4), .rst(rst), .btn(btnC), .press(press_c));
  button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_u (
    .clk(clkX4), .rst(rst), .btn(btnU), .press(press_u));
  button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_d (
    .clk(clkX4), .rst(rst), .btn(btnD), .press(press_d));

  assign in_cycle = (state_q == CS_RUN) || (state_q == CS_STEP);
  assign pulse    = in_cycle && (phase_q == PW'(PHASES - 1));
  // count_q is the value before this pulse's increment, hence the -1.
  assign halt_now = cpuHaltReq ||
                    ((MAX_CYCLES != 0) && (count_q >= 32'(MAX_CYCLES - 1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      CS_RESET_HOLD: if (hold_q == HW'(RST_HOLD_CYCLES - 1)) state_d = CS_IDLE;
      CS_IDLE: begin
        if (press_c || press_u) begin
          if (cpuHaltReq)   state_d = CS_HALTED;
          else if (press_c) state_d = CS_RUN;
          else              state_d = CS_STEP;
        end
      end
      CS_RUN: begin
        if (pulse) begin
          if (halt_now)                state_d = CS_HALTED;
          else if (pause_q || press_c) state_d = CS_IDLE;
        end
      end
      CS_STEP:   if (pulse) state_d = halt_now ? CS_HALTED : CS_IDLE;
      CS_HALTED: state_d = CS_HALTED;
      default:   state_d = CS_RESET_HOLD;
    endcase
    if (press_d) state_d = CS_RESET_HOLD;
  end

  always_ff @(posedge clkX4) begin
    if (rst) begin
      state_q <= CS_RESET_HOLD;
      phase_q <= '0;
      hold_q  <= '0;
      pause_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // Any state change (entry, exit or restart) restarts the phase at 0.
      phase_q <= (in_cycle && (state_d == state_q)) ? phase_q + 1'b1 : '0;
      hold_q  <= ((state_q == CS_RESET_HOLD) && (state_d == CS_RESET_HOLD) && !press_d)
                 ? hold_q + 1'b1 : '0;
      pause_q <= (state_q == CS_RUN) && (state_d == CS_RUN) && (pause_q || press_c);
      if (state_d == CS_RESET_HOLD) count_q <= '0;
      else if (pulse)               count_q <= sat_inc32(count_q);
    end
  end

  assign cpuRst     = (state_q == CS_RESET_HOLD);
  assign cpuClkEn   = pulse;
  assign cpuPhase   = phase_q;
  assign runState   = state_q;
  assign cycleCount = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: reset hold, run, pause, step, halt,
// restart, glitch rejection, mid-run reset and the MAX_CYCLES limit.
module tb_cpu_run_controller;
  import cpu_run_controller_pkg::*;

  logic clk = 1'b0;
  logic rst, btnC, btnU, btnD, cpuHaltReq;
  logic cpu_rst, cpu_clk_en, cpu_rst_m, cpu_clk_en_m;
  logic [1:0] cpu_phase, cpu_phase_m;
  ControllerState run_state, run_state_m;
  logic [31:0] cycle_count, cycle_count_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_run_controller #(.PHASES(4), .DEBOUNCE_CYCLES(4), .RST_HOLD_CYCLES(8), .MAX_CYCLES(0)) dut (
    .clkX4(clk), .rst(rst), .btnC(btnC), .btnU(btnU), .btnD(btnD), .cpuHaltReq(cpuHaltReq),
    .cpuRst(cpu_rst), .cpuClkEn(cpu_clk_en), .cpuPhase(cpu_phase), .runState(run_state),
    .cycleCount(cycle_count));

  cpu_run_controller #(.PHASES(4), .DEBOUNCE_CYCLES(4), .RST_HOLD_CYCLES(8), .MAX_CYCLES(5)) dut_max (
    .clkX4(clk), .rst(rst), .btnC(btnC), .btnU(btnU), .btnD(btnD), .cpuHaltReq(cpuHaltReq),
    .cpuRst(cpu_rst_m), .cpuClkEn(cpu_clk_en_m), .cpuPhase(cpu_phase_m), .runState(run_state_m),
    .cycleCount(cycle_count_m));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btnC = 1'b0; btnU = 1'b0; btnD = 1'b0; cpuHaltReq = 1'b0;

    // Reset and the 8-cycle CPU reset hold
    tick(3);
    check("rst_state", run_state, CS_RESET_HOLD);
    check("rst_cpurst", cpu_rst, 1'b1);
    check("rst_clken", cpu_clk_en, 1'b0);
    check("rst_phase", cpu_phase, 2'd0);
    check("rst_count", cycle_count, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("hold_cpurst", cpu_rst, 1'b1);
      check("hold_clken", cpu_clk_en, 1'b0);
      tick(1);
    end
    check("hold_release", cpu_rst, 1'b0);
    check("hold_idle", run_state, CS_IDLE);

    // Run: press latency 2+4, pulses every 4th cycle, 10 pulses in 40 cycles
    btnC = 1'b1;
    tick(6);
    check("run_latency_idle", run_state, CS_IDLE);
    tick(1);
    check("run_entered", run_state, CS_RUN);
    check("run_phase0", cpu_phase, 2'd0);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 2) btnC = 1'b0;
      check("run_clken", cpu_clk_en, ((i + 1) % 4 == 3) ? 1'b1 : 1'b0);
    end
    check("run_count40", cycle_count, 32'd10);

    // Pause: press accepted at phase 1, one more pulse at phase 3, then idle
    tick(3);
    btnC = 1'b1;
    tick(6);
    btnC = 1'b0;
    check("pause_phase1", cpu_phase, 2'd1);
    check("pause_still_run", run_state, CS_RUN);
    check("pause_count", cycle_count, 32'd12);
    tick(2);
    check("pause_last_pulse", cpu_clk_en, 1'b1);
    tick(1);
    check("pause_idle", run_state, CS_IDLE);
    check("pause_count_final", cycle_count, 32'd13);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("pause_no_pulse", cpu_clk_en, 1'b0);
    end

    // Halt request at a pulse, then buttons ignored, then restart via btnD
    btnC = 1'b1;
    tick(6);
    btnC = 1'b0;
    tick(1);
    check("halt_run", run_state, CS_RUN);
    tick(5);
    cpuHaltReq = 1'b1;
    tick(2);
    check("halt_pulse", cpu_clk_en, 1'b1);
    tick(1);
    check("halt_state", run_state, CS_HALTED);
    check("halt_count", cycle_count, 32'd15);
    cpuHaltReq = 1'b0;
    btnC = 1'b1;
    btnU = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (i == 7) begin
        btnC = 1'b0;
        btnU = 1'b0;
      end
      check("halt_no_pulse", cpu_clk_en, 1'b0);
    end
    check("halt_ignores_btns", run_state, CS_HALTED);
    btnD = 1'b1;
    tick(6);
    btnD = 1'b0;
    check("restart_pending", run_state, CS_HALTED);
    tick(1);
    check("restart_state", run_state, CS_RESET_HOLD);
    check("restart_count", cycle_count, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("restart_cpurst", cpu_rst, 1'b1);
      tick(1);
    end
    check("restart_release", cpu_rst, 1'b0);
    check("restart_idle", run_state, CS_IDLE);

    // Single step
    btnU = 1'b1;
    tick(6);
    btnU = 1'b0;
    check("step_latency_idle", run_state, CS_IDLE);
    tick(1);
    check("step_entered", run_state, CS_STEP);
    check("step_count0", cycle_count, 32'd0);
    tick(3);
    check("step_pulse", cpu_clk_en, 1'b1);
    check("step_phase3", cpu_phase, 2'd3);
    tick(1);
    check("step_idle", run_state, CS_IDLE);
    check("step_count1", cycle_count, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("step_no_pulse", cpu_clk_en, 1'b0);
    end

    // Glitch shorter than the debounce window
    btnC = 1'b1;
    tick(2);
    btnC = 1'b0;
    tick(12);
    check("glitch_idle", run_state, CS_IDLE);

    // rst mid-run aborts on the next edge
    btnC = 1'b1;
    tick(6);
    btnC = 1'b0;
    tick(1);
    check("midrst_run", run_state, CS_RUN);
    tick(6);
    check("midrst_phase2", cpu_phase, 2'd2);
    check("midrst_count", cycle_count, 32'd2);
    rst = 1'b1;
    tick(1);
    check("midrst_cpurst", cpu_rst, 1'b1);
    check("midrst_clken", cpu_clk_en, 1'b0);
    check("midrst_count0", cycle_count, 32'd0);
    check("midrst_state", run_state, CS_RESET_HOLD);
    check("midrst_phase0", cpu_phase, 2'd0);
    rst = 1'b0;
    tick(8);
    check("midrst_idle", run_state, CS_IDLE);
    check("max_idle", run_state_m, CS_IDLE);

    // MAX_CYCLES=5 limit on the second instance
    btnC = 1'b1;
    tick(6);
    btnC = 1'b0;
    tick(1);
    check("max_run", run_state_m, CS_RUN);
    tick(20);
    check("max_halted", run_state_m, CS_HALTED);
    check("max_count", cycle_count_m, 32'd5);
    check("unlimited_run", run_state, CS_RUN);
    check("unlimited_count", cycle_count, 32'd5);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("max_no_pulse", cpu_clk_en_m, 1'b0);
    end
    check("max_count_hold", cycle_count_m, 32'd5);
    check("unlimited_count2", cycle_count, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
